// File: rtl/pwm_demod_pkg.sv
// Shared definitions for the PWM demodulator and its companion modulator.
package pwm_demod_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic {
        SEARCH = 1'b0,
        TRACK  = 1'b1
    } state_t;

endpackage

// File: rtl/pwm_demod_sync_edge.sv
// Metastability synchronizer for the asynchronous PWM input plus rising-edge detect.
module pwm_demod_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   dly_q, dly_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        dly_d  = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~dly_q;

endmodule

// File: rtl/pwm_demod.sv
// Recovers one signed sample per 2^WIDTH-cycle PWM frame by counting high cycles,
// aligning frames on the rising edge that starts each frame.
module pwm_demod
    import pwm_demod_pkg::*;
#(
    parameter int unsigned WIDTH       = DEFAULT_WIDTH,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] sample,
    output logic             sample_valid,
    output logic             locked,
    output logic             sync_err
);

    localparam int unsigned N_LAST = (1 << WIDTH) - 1;
    localparam int unsigned HALF   = 1 << (WIDTH - 1);
    localparam int unsigned DW     = WIDTH + 2;

    logic pwm_s;
    logic rise;

    state_t state_q, state_d;

    logic [WIDTH-1:0] wcnt_q, wcnt_d;
    logic [WIDTH:0]   hcnt_q, hcnt_d;
    logic [WIDTH-1:0] sample_q, sample_d;
    logic             sample_valid_q, sample_valid_d;
    logic             locked_q, locked_d;
    logic             sync_err_q, sync_err_d;

    logic              frame_end_c;
    logic              mid_rise_c;
    logic [WIDTH:0]    h_c;
    logic signed [DW-1:0] diff_c;
    logic [WIDTH-1:0]  sat_c;

    pwm_demod_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_in(pwm_in),
        .level   (pwm_s),
        .rise    (rise)
    );

    // Frame-end high count and its saturated bipolar mapping; H = N clips to +max.
    always_comb begin
        frame_end_c = (wcnt_q == WIDTH'(N_LAST));
        mid_rise_c  = rise && (wcnt_q != '0);
        h_c         = hcnt_q + (WIDTH+1)'(pwm_s);
        diff_c      = $signed({1'b0, h_c}) - $signed(DW'(HALF));
        if (diff_c > $signed(DW'(HALF - 1))) begin
            sat_c = WIDTH'(HALF - 1);
        end else begin
            sat_c = diff_c[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEARCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SEARCH:  if (rise) state_d = TRACK;
            TRACK:   state_d = TRACK;
            default: state_d = SEARCH;
        endcase
    end

    // A rise anywhere but the first cycle of a frame (including the last one) resyncs.
    always_comb begin
        wcnt_d         = wcnt_q;
        hcnt_d         = hcnt_q;
        sample_d       = sample_q;
        sample_valid_d = 1'b0;
        locked_d       = locked_q;
        sync_err_d     = sync_err_q;
        unique case (state_q)
            SEARCH: begin
                locked_d = 1'b0;
                if (rise) begin
                    wcnt_d = WIDTH'(1);
                    hcnt_d = (WIDTH+1)'(1);
                end else begin
                    wcnt_d = '0;
                    hcnt_d = '0;
                end
            end
            TRACK: begin
                if (mid_rise_c) begin
                    wcnt_d     = WIDTH'(1);
                    hcnt_d     = (WIDTH+1)'(1);
                    sync_err_d = 1'b1;
                    locked_d   = 1'b0;
                end else if (frame_end_c) begin
                    sample_d       = sat_c;
                    sample_valid_d = 1'b1;
                    locked_d       = 1'b1;
                    wcnt_d         = '0;
                    hcnt_d         = '0;
                end else begin
                    wcnt_d = wcnt_q + WIDTH'(1);
                    hcnt_d = h_c;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q         <= '0;
            hcnt_q         <= '0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            sync_err_q     <= 1'b0;
        end else begin
            wcnt_q         <= wcnt_d;
            hcnt_q         <= hcnt_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            locked_q       <= locked_d;
            sync_err_q     <= sync_err_d;
        end
    end

    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
    assign locked       = locked_q;
    assign sync_err     = sync_err_q;

endmodule

// File: doc/pwm_demod.md
PWM_DEMOD -- requirements
Module: pwm_demod

Interface
REQ-001 SHALL have parameter WIDTH, default 8: sample width; frame length N = 2^WIDTH clk cycles.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on pwm_in, legal range 2..4.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port pwm_in  input  1  PWM stream, asynchronous to clk.
REQ-006 SHALL have port sample  output  WIDTH  signed reconstructed sample, held between updates.
REQ-007 SHALL have port sample_valid  output  1  one-cycle pulse when sample updates.
REQ-008 SHALL have port locked  output  1  high while frame alignment is established.
REQ-009 SHALL have port sync_err  output  1  sticky flag, set on any mid-frame rising edge; cleared only by reset.

Function
REQ-010 SHALL pass pwm_in through a SYNC_STAGES flop chain (pwm_s) and one extra flop for rising-edge detect (rise = pwm_s & ~pwm_d).
REQ-011 SHALL run a two-state FSM: SEARCH (reset state) and TRACK.
REQ-012 In SEARCH: counters held at 0, no sample_valid; on rise -> TRACK with wcnt=1, hcnt=1.
REQ-013 In TRACK: wcnt (WIDTH bits) increments each cycle; hcnt (WIDTH+1 bits) adds pwm_s each cycle.
REQ-014 Frame end is the cycle with wcnt==N-1: H = hcnt + pwm_s; next cycle sample = sat(H - 2^(WIDTH-1)), sample_valid=1; wcnt, hcnt <= 0.
REQ-015 Saturation: H in 0..N maps to -2^(WIDTH-1)..+2^(WIDTH-1); H=N SHALL clamp to +2^(WIDTH-1)-1 (127 at WIDTH=8); arithmetic in WIDTH+2 bits signed, no wrap.
REQ-016 rise in TRACK with wcnt==0 SHALL be the normal frame start (no action beyond counting).
REQ-017 rise in TRACK with wcnt!=0 SHALL discard the partial frame, set sync_err, restart with wcnt=1, hcnt=1, no sample_valid that cycle.
REQ-018 Rise coincident with frame end (wcnt==N-1) SHALL count as mid-frame (REQ-017 wins; frame discarded).
REQ-019 Constant-low or constant-high input in TRACK SHALL keep producing frames (-128 / +127 at WIDTH=8) every N cycles, lock kept.
REQ-020 locked SHALL be 0 in SEARCH, 1 from the first completed frame in TRACK; deasserted for one full frame after any REQ-017 resync.
REQ-021 Latency pwm_in edge to sample_valid: SYNC_STAGES + N + 1 cycles for a frame starting at that edge.

Reset
REQ-022 Asynchronous assert on rst_n low: FSM=SEARCH, sync chain=0, wcnt=hcnt=0, sample=0, sample_valid=0, locked=0, sync_err=0.
REQ-023 Reset mid-frame SHALL discard partial counts; first output after release needs a new rise plus full frame.
REQ-024 Release SHALL be synchronous to clk via the existing reset synchronizer upstream; no internal reset stretching.

Structure
REQ-025 Shared package SHALL hold FSM state typedef (SEARCH, TRACK) and default WIDTH constant, shared with pmod_pwm.
REQ-026 Synchronizer plus edge detect SHALL be one sub-module, sync_edge (params SYNC_STAGES; outputs level, rise).
REQ-027 No other hierarchy; target 150-250 lines RTL.

Verification
REQ-028 Bench SHALL drive pwm_in from pmod_pwm with sample ramp -128 -> +127 (+1 per frame) -> recovered sample sequence equals driven sequence, delayed, no sync_err.
REQ-029 Constant sample 0 (H=128) -> sample=0 every 256 cycles, locked=1 after first frame.
REQ-030 pwm_in held 1 after one rise -> sample=+127 each frame; held 0 -> sample=-128, locked stays 1.
REQ-031 Extra rise injected at wcnt=100 -> sync_err=1 sticky, that frame dropped, locked low one frame, next valid sample correct.
REQ-032 rst_n pulsed low mid-frame (wcnt=50) -> all outputs 0 immediately, no sample_valid until rise + 256 cycles.
REQ-033 Parameter WIDTH=4 build, duty 3/16 -> sample=-5 every 16 cycles.
